// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative signed 32-step shift-add multiply / restoring divide
//            writing HI/LO, with done and divide-by-zero pulses.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_DZ   = 2'd3;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   step_acc, step_shf;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Two's-complement magnitude kept unsigned so -2^(W-1) maps to 2^(W-1).
  assign mag_a = a_in[WIDTH-1] ? ((~a_in) + WIDTH'(1)) : a_in;
  assign mag_b = b_in[WIDTH-1] ? ((~b_in) + WIDTH'(1)) : b_in;

  // Multiply: acc holds the running high half, shf the multiplier/low half.
  // Divide: acc holds the partial remainder, shf the dividend/quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, shf_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (op_q) begin
      step_acc = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_shf = {shf_q[WIDTH-2:0], div_ge};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_shf = {mul_sum[0], shf_q[WIDTH-1:1]};
    end
    prod_raw = {step_acc, step_shf};
    prod_fix = res_neg_q ? ((~prod_raw) + (2*WIDTH)'(1)) : prod_raw;
    quot_fix = res_neg_q ? ((~step_shf) + WIDTH'(1)) : step_shf;
    rem_fix  = rem_neg_q ? ((~step_acc) + WIDTH'(1)) : step_acc;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    shf_d     = shf_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op && (b_in == '0)) begin
            state_d = S_DZ;
          end else begin
            state_d   = S_RUN;
            cnt_d     = '0;
            op_d      = op;
            res_neg_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            rem_neg_d = a_in[WIDTH-1];
            acc_d     = '0;
            opnd_d    = op ? mag_b : mag_a;
            shf_d     = op ? mag_a : mag_b;
          end
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        shf_d = step_shf;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (op_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DZ:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      shf_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      shf_q     <= shf_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign div0 = (state_q == S_DZ);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Scoreboard bench for mult_div_unit with a plain-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    bit          is_div0;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_in(reset_in), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .div0(div0),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed 64-bit arithmetic; C-style truncating / and % give
  // the quotient/remainder signs required, including the -2^31 / -1 wrap.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb_v, p, q, r;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    e.cyc = cyc + (o && b == 0 ? 1 : 33);
    if (o && b == 0) begin
      e.is_div0 = 1'b1;
    end else if (o) begin
      q = sa / sb_v;
      r = sa % sb_v;
      model_lo = q[31:0];
      model_hi = r[31:0];
      e.is_div0 = 1'b0;
    end else begin
      p = sa * sb_v;
      model_hi = p[63:32];
      model_lo = p[31:0];
      e.is_div0 = 1'b0;
    end
    e.hi = model_hi;
    e.lo = model_lo;
    sb.push_back(e);
    step();
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  task automatic expect_busy(input int n);
    repeat (n) begin
      check("busy_high", {31'b0, busy}, 32'd1);
      step();
    end
  endtask

  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    expect_busy((o && b == 0) ? 1 : 33);
    check("busy_low_after", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      step();
      k++;
    end
    if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3: begin
        v = $urandom_range(0, 20);
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: every done/div0 pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (done || div0) begin
      exp_t e;
      check("pulse_exclusive", {31'b0, done && div0}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'b0, done, div0}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {31'b0, div0}, {31'b0, e.is_div0});
        check("pulse_cycle", cyc, e.cyc);
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b0;
    repeat (3) step();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_div0", {31'b0, div0}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset_in = 1'b1;
    step();

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op(1'b0, 32'd6, 32'h2AAA_AAAB);
    run_op(1'b1, 32'd5, 32'd0);
    check("div0_keeps_hi", hi, 32'h1);
    check("div0_keeps_lo", lo, 32'h2);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000);

    // Start re-pulsed mid-run must be ignored.
    issue(1'b0, 32'd3, 32'd4);
    repeat (4) step();
    start = 1'b1; op = 1'b1; a_in = 32'd9; b_in = 32'd0;
    step();
    start = 1'b0;
    wait_idle();
    step();

    // Reset mid-run aborts with no pulse and clears HI/LO.
    issue(1'b0, 32'd3, 32'd4);
    repeat (9) step();
    reset_in = 1'b0;
    step();
    reset_in = 1'b1;
    sb.delete();
    model_hi = '0;
    model_lo = '0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (40) step();

    // Start in the DONE cycle is ignored; start in the next IDLE cycle is taken.
    issue(1'b0, 32'd11, 32'd13);
    expect_busy(32);
    check("done_cycle", {31'b0, done}, 32'd1);
    start = 1'b1; op = 1'b1; a_in = 32'd1; b_in = 32'd0;
    step();
    check("idle_after_done", {31'b0, busy}, 32'd0);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), rand_opnd(), rand_opnd());
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
